lc3_mem_responder: RTL
======================

Name: lc3_mem_responder

Overview:
- Memory-side responder for the LC-3 datapath's MAR/MDR memory interface.
- Accepts read/write requests qualified by MEM_EN/WE and sequences an external asynchronous SRAM with a fixed wait-state count.
- Decodes memory-mapped I/O at IO_ADDR: switches on read, hex-display latch on write.
- Returns read data and a one-cycle ready pulse R to the control FSM.

Parameters:
- WAIT_STATES, 2, SRAM access cycles per request; legal range 1..15.
- IO_ADDR, 16'hFFFF, address decoded as the MMIO switch/hex register.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Reset_ah  input  1  synchronous, active-high reset.
- MEM_EN  input  1  request valid from control FSM; held until R is seen.
- WE  input  1  1 = write, 0 = read; sampled with MEM_EN.
- MAR  input  16  request address.
- MDR  input  16  write data.
- Switches  input  16  MMIO read source.
- Data_to_CPU  output  16  registered read data, feeds datapath MDR_In.
- R  output  1  ready; one-cycle pulse on completion.
- HEX_Out  output  16  MMIO hex-display register.
- SRAM_ADDR  output  16  SRAM address.
- SRAM_DQ_Out  output  16  SRAM write data.
- SRAM_DQ_In  input  16  SRAM read data.
- SRAM_CE_N  output  1  chip enable, active low.
- SRAM_OE_N  output  1  output enable, active low.
- SRAM_WE_N  output  1  write enable, active low.
- LED_Out  output  16  MMIO LED register; present only with MMIO_LED_EN.

Behaviour:
- States: IDLE, ACCESS, DONE, HOLD (2-bit encoding).
- IDLE, MEM_EN=1 at an edge:
  - Latch MAR into addr_q, MDR into wdata_q, WE into we_q.
  - If MAR==IO_ADDR, go directly to DONE.
  - Otherwise load wait_cnt=WAIT_STATES-1 and go to ACCESS.
- IDLE, MEM_EN=0: remain in IDLE.
- ACCESS:
  - SRAM_CE_N=0 throughout.
  - Read: SRAM_OE_N=0, SRAM_WE_N=1.
  - Write: SRAM_WE_N=0, SRAM_OE_N=1.
  - wait_cnt decrements each cycle. When wait_cnt==0, the read path captures SRAM_DQ_In into Data_to_CPU at that edge, and the state goes to DONE.
- DONE:
  - R=1 for exactly this one cycle; all SRAM strobes inactive.
  - MMIO read: Data_to_CPU<=Switches at the IDLE->DONE edge.
  - MMIO write: HEX_Out<=wdata_q at the IDLE->DONE edge.
  - Always go to HOLD next.
- HOLD:
  - Wait for MEM_EN=0, then go to IDLE. This prevents double writes while the control FSM is still asserting.
  - MEM_EN deasserted during ACCESS: the access still completes; the protocol forbids it.
- Latency: SRAM request R arrives WAIT_STATES+1 cycles after the accept edge; MMIO request 1 cycle.
- Output registers and defaults:
  - SRAM_ADDR=addr_q and SRAM_DQ_Out=wdata_q, both registered.
  - Strobes are decoded from state and we_q; all strobes are 1 outside ACCESS.
  - Data_to_CPU holds its value until the next read completes; writes leave it unchanged.
- Back-to-back requests: minimum of one IDLE cycle between requests.
- Reset_ah (any state, including mid-ACCESS):
  - Next edge: state=IDLE, R=0, all strobes=1, Data_to_CPU=0, HEX_Out=0, LED_Out=0, addr_q=0, wdata_q=0, wait_cnt=0.
  - An interrupted write is abandoned; SRAM contents are undefined for that address.
- Addresses 0x0000..IO_ADDR-1 go to SRAM. Only the exact IO_ADDR match (plus LED address when enabled) is MMIO.

Optional Feature:
- Macro: MMIO_LED_EN.
- With it defined:
  - Address IO_ADDR-1 (0xFFFE) is a read/write LED register.
  - Write: LED_Out<=wdata_q in 1 cycle.
  - Read: returns LED_Out.
  - LED_Out port exists.
- Without it: 0xFFFE is ordinary SRAM and the LED_Out port is absent.

Decomposition:
- Shared package lc3_mem_pkg:
  - enum mem_state_t {IDLE, ACCESS, DONE, HOLD}.
  - Localparams IO_ADDR_DEFAULT=16'hFFFF, LED_ADDR=16'hFFFE.
  - Typedef word_t = logic [15:0].
- One natural sub-module: wait_counter (loadable 4-bit down-counter with zero flag), instantiated once.

Test Plan:
- Reset then idle: after Reset_ah, R=0, SRAM_CE_N/OE_N/WE_N=1, Data_to_CPU=0, HEX_Out=0.
- Write then read, WAIT_STATES=2:
  - Write MAR=0x3000, MDR=0xBEEF, WE=1: SRAM_WE_N low for exactly 2 cycles with SRAM_ADDR=0x3000, SRAM_DQ_Out=0xBEEF; R pulses on cycle 3.
  - Read of 0x3000 with model returning 0xBEEF: Data_to_CPU=0xBEEF when R=1.
- MMIO:
  - Switches=0x1234, read MAR=0xFFFF: R one cycle after accept, Data_to_CPU=0x1234, no SRAM strobe asserted.
  - Write MAR=0xFFFF, MDR=0x00A5: HEX_Out=0x00A5.
- HOLD: keep MEM_EN=1 for 5 cycles after R: exactly one SRAM write (one WE_N low burst); next request accepted only after MEM_EN=0 for one cycle.
- Reset mid-ACCESS: assert Reset_ah in the first ACCESS cycle of a write: next cycle all strobes=1, state IDLE, R never pulses, HEX_Out=0.
- MMIO_LED_EN build: write 0xFFFE <= 0x00FF, then read 0xFFFE: LED_Out=0x00FF and Data_to_CPU=0x00FF. Non-LED build: same write produces an SRAM WE_N burst instead.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package lc3_mem_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        HOLD   = 2'd3
    } mem_state_t;

    localparam word_t IO_ADDR_DEFAULT = 16'hFFFF;
    localparam word_t LED_ADDR        = 16'hFFFE;

endpackage

// File: rtl/wait_counter.sv
// Loadable 4-bit down-counter that saturates at zero; zero flag marks the last wait state.
module wait_counter (
    input  logic       clk,
    input  logic       srst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       zero
);

    logic [3:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= 4'd0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != 4'd0)) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign zero = (count_reg == 4'd0);

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: sequences an async SRAM with fixed wait states and decodes MMIO.
// Optional LED register at IO_ADDR-1 is enabled by defining MMIO_LED_EN.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int    WAIT_STATES = 2,
    parameter word_t IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset_ah,
    input  logic        MEM_EN,
    input  logic        WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] Switches,
    output logic [15:0] Data_to_CPU,
    output logic        R,
    output logic [15:0] HEX_Out,
    output logic [15:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_Out,
    input  logic [15:0] SRAM_DQ_In,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
`ifdef MMIO_LED_EN
    ,
    output logic [15:0] LED_Out
`endif
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    mem_state_t state_reg;
    word_t      addr_reg;
    word_t      wdata_reg;
    word_t      dout_reg;
    word_t      hex_reg;
    logic       we_reg;
    logic       r_reg;
    logic       ce_n_reg;
    logic       oe_n_reg;
    logic       we_n_reg;

    logic       is_io;
    logic       is_led;
    logic       is_mmio;
    logic       cnt_load;
    logic       cnt_zero;

`ifdef MMIO_LED_EN
    localparam word_t LED_SEL = IO_ADDR - 16'd1;
    word_t led_reg;
    assign is_led  = (MAR == LED_SEL);
    assign LED_Out = led_reg;
`else
    assign is_led = 1'b0;
`endif

    assign is_io    = (MAR == IO_ADDR);
    assign is_mmio  = is_io | is_led;
    assign cnt_load = (state_reg == IDLE) && MEM_EN && !is_mmio;

    wait_counter u_wait_counter (
        .clk      (Clk),
        .srst     (Reset_ah),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .en       (state_reg == ACCESS),
        .zero     (cnt_zero)
    );

    // Strobes and R are registered alongside the state so they never glitch.
    always_ff @(posedge Clk) begin
        if (Reset_ah) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            dout_reg  <= '0;
            hex_reg   <= '0;
            we_reg    <= 1'b0;
            r_reg     <= 1'b0;
            ce_n_reg  <= 1'b1;
            oe_n_reg  <= 1'b1;
            we_n_reg  <= 1'b1;
`ifdef MMIO_LED_EN
            led_reg   <= '0;
`endif
        end else begin
            r_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (MEM_EN) begin
                        addr_reg  <= MAR;
                        wdata_reg <= MDR;
                        we_reg    <= WE;
                        if (is_mmio) begin
                            state_reg <= DONE;
                            r_reg     <= 1'b1;
                            if (is_io) begin
                                if (WE) hex_reg  <= MDR;
                                else    dout_reg <= Switches;
                            end
`ifdef MMIO_LED_EN
                            if (is_led) begin
                                if (WE) led_reg  <= MDR;
                                else    dout_reg <= led_reg;
                            end
`endif
                        end else begin
                            state_reg <= ACCESS;
                            ce_n_reg  <= 1'b0;
                            oe_n_reg  <= WE;
                            we_n_reg  <= !WE;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_zero) begin
                        if (!we_reg) dout_reg <= SRAM_DQ_In;
                        state_reg <= DONE;
                        r_reg     <= 1'b1;
                        ce_n_reg  <= 1'b1;
                        oe_n_reg  <= 1'b1;
                        we_n_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= HOLD;
                end
                HOLD: begin
                    // Re-arm only once the requester drops MEM_EN, so a held request is served once.
                    if (!MEM_EN) state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign Data_to_CPU = dout_reg;
    assign R           = r_reg;
    assign HEX_Out     = hex_reg;
    assign SRAM_ADDR   = addr_reg;
    assign SRAM_DQ_Out = wdata_reg;
    assign SRAM_CE_N   = ce_n_reg;
    assign SRAM_OE_N   = oe_n_reg;
    assign SRAM_WE_N   = we_n_reg;

endmodule
